// File: rtl/axi_addr_fifo_sync.sv
// Single-clock FWFT FIFO for AXI AR/AW address beats with level, watermark flags and flush.
// Storage is a flop array with an asynchronous read port, so a push into an empty FIFO is visible right after the edge.
module axi_addr_fifo_sync #(
  parameter int DATA_WIDTH       = 44,
  parameter int DEPTH_WIDTH      = 6,
  parameter int ALMOST_FULL_NUM  = 60,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_L = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_L    = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_L    = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  if (ALMOST_FULL_NUM > DEPTH || ALMOST_EMPTY_NUM >= DEPTH) begin : g_param_chk
    $error("axi_addr_fifo_sync: watermark thresholds out of range for DEPTH");
  end

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic                   init_done_q, init_done_d;
  logic                   push, pop;

  // All flags come from the registered count so they move together with water_level.
  assign water_level  = count_q;
  assign full         = (count_q == DEPTH_L);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);

  assign s_ready = init_done_q & ~full & ~flush;
  assign m_valid = ~empty;
  assign m_data  = m_valid ? mem[rd_ptr_q] : '0;

  // A handshake during flush is dropped; flush wins over both sides.
  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    init_done_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end
endmodule
